// File: rtl/irq_capture_pkg.sv
// Shared constants and types for the IRQ capture slave: CSR map, flag bit
// positions and the CSR read FSM states.
package irq_capture_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_CLEAR  = 4'd1;
  localparam logic [3:0] ADDR_MASK   = 4'd2;
  localparam logic [3:0] ADDR_COUNT  = 4'd3;
  localparam logic [3:0] ADDR_ID     = 4'd4;

  localparam int BIT_PENDING  = 0;
  localparam int BIT_OVERFLOW = 1;
  localparam int BIT_ENABLE   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/irq_event_counter.sv
// Saturating event counter; an increment coinciding with a clear loads 1 so
// the event that raced the clear is not lost.
module irq_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && clr_i) begin
      count_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/irq_capture_slave.sv
// Avalon-MM interrupt capture: trigger writes latch pending/overflow flags and
// bump an event counter; the CPU reads/clears them through a 1-wait CSR port.
module irq_capture_slave
  import irq_capture_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] ID_VALUE = 32'h4952_5131
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig_chipselect,
  input  logic        trig_write,
  input  logic [31:0] trig_writedata,
  output logic        trig_waitrequest,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        csr_waitrequest,
  output logic        irq
);

  rd_state_e        state_q, state_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             enable_q, enable_d;
  logic             irq_q;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rd_mux;
  logic [CNT_W-1:0] count;
  logic             trig_evt, wr_ok, clr_pend, clr_ovf, ovf_set, cnt_clr;
  logic             unused_ok;

  assign unused_ok = ^{trig_writedata[31:1], csr_writedata[31:2]};

  assign trig_evt = trig_chipselect & trig_write & trig_writedata[0];
  // A read in flight owns the port; a concurrent write strobe is dropped.
  assign wr_ok    = csr_write & ~csr_read;
  assign clr_pend = wr_ok & (csr_address == ADDR_CLEAR) & csr_writedata[BIT_PENDING];
  assign clr_ovf  = wr_ok & (csr_address == ADDR_CLEAR) & csr_writedata[BIT_OVERFLOW];
  assign cnt_clr  = wr_ok & (csr_address == ADDR_COUNT);
  assign ovf_set  = trig_evt & pending_q & ~clr_pend;

  always_comb begin
    pending_d  = trig_evt ? 1'b1 : (clr_pend ? 1'b0 : pending_q);
    overflow_d = ovf_set  ? 1'b1 : (clr_ovf  ? 1'b0 : overflow_q);
    enable_d   = enable_q;
    if (wr_ok && (csr_address == ADDR_MASK)) enable_d = csr_writedata[BIT_ENABLE];
  end

  irq_event_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (trig_evt),
    .clr_i   (cnt_clr),
    .count_o (count)
  );

  always_comb begin
    rd_mux = 32'h0;
    case (csr_address)
      ADDR_STATUS: begin
        rd_mux[BIT_PENDING]  = pending_q;
        rd_mux[BIT_OVERFLOW] = overflow_q;
      end
      ADDR_MASK:  rd_mux[BIT_ENABLE] = enable_q;
      ADDR_COUNT: rd_mux[CNT_W-1:0]  = count;
      ADDR_ID:    rd_mux = ID_VALUE;
      default:    rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    readdata_d      = readdata_q;
    csr_waitrequest = 1'b0;
    case (state_q)
      IDLE: begin
        csr_waitrequest = csr_read;
        if (csr_read) begin
          readdata_d = rd_mux;
          state_d    = RDATA;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      readdata_q <= 32'h0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
      irq_q      <= pending_q & enable_q;
    end
  end

  assign csr_readdata     = readdata_q;
  assign trig_waitrequest = 1'b0;
  assign irq              = irq_q;

endmodule

// File: tb/tb_irq_capture_slave.sv
// Directed bench for irq_capture_slave (CNT_W=4 so saturation is reachable);
// read expectations go through a scoreboard queue popped when data returns.
module tb_irq_capture_slave;
  import irq_capture_pkg::*;

  localparam logic [31:0] ID = 32'h4952_5131;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig_chipselect, trig_write;
  logic [31:0] trig_writedata;
  logic        trig_waitrequest;
  logic [3:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        csr_waitrequest, irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  irq_capture_slave #(.CNT_W(4), .ID_VALUE(ID)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trig_chipselect  (trig_chipselect),
    .trig_write       (trig_write),
    .trig_writedata   (trig_writedata),
    .trig_waitrequest (trig_waitrequest),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_readdata     (csr_readdata),
    .csr_waitrequest  (csr_waitrequest),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic csr_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    int waits;
    logic [31:0] e;
    waits = 0;
    exp_q.push_back(exp);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clk);
    while (csr_waitrequest === 1'b1 && waits < 4) begin
      waits++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({tag, "_data"}, csr_readdata, e);
    check({tag, "_wait"}, 32'(waits), 32'd1);
    tick();
    csr_read = 1'b0;
  endtask

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic trig(input int n);
    trig_chipselect = 1'b1;
    trig_write      = 1'b1;
    trig_writedata  = 32'h1;
    repeat (n) tick();
    trig_chipselect = 1'b0;
    trig_write      = 1'b0;
    trig_writedata  = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    trig_chipselect = 1'b0; trig_write = 1'b0; trig_writedata = 32'h0;
    csr_address = 4'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'h0;
    repeat (3) tick();
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_trig_wait", {31'h0, trig_waitrequest}, 32'h0);
    check("rst_csr_wait", {31'h0, csr_waitrequest}, 32'h0);
    rst_n = 1'b1;
    tick();

    csr_rd(ADDR_STATUS, 32'h0, "rst_status");
    csr_rd(ADDR_CLEAR,  32'h0, "rst_clear");
    csr_rd(ADDR_MASK,   32'h0, "rst_mask");
    csr_rd(ADDR_COUNT,  32'h0, "rst_count");
    csr_rd(ADDR_ID,     ID,    "id");
    csr_rd(4'd9,        32'h0, "unmapped");
    check("rst_irq2", {31'h0, irq}, 32'h0);

    // Single event with interrupts enabled
    csr_wr(ADDR_MASK, 32'h1);
    csr_rd(ADDR_MASK, 32'h1, "mask_set");
    trig(1);
    @(negedge clk);
    check("evt_irq_c1", {31'h0, irq}, 32'h0);
    tick();
    @(negedge clk);
    check("evt_irq_c2", {31'h0, irq}, 32'h1);
    tick();
    csr_rd(ADDR_STATUS, 32'h1, "evt_status");
    csr_wr(ADDR_CLEAR, 32'h1);
    @(negedge clk);
    check("clr_irq_c1", {31'h0, irq}, 32'h1);
    tick();
    @(negedge clk);
    check("clr_irq_c2", {31'h0, irq}, 32'h0);
    tick();
    csr_rd(ADDR_COUNT, 32'h1, "evt_count");

    // Non-events on the trigger port, then three back-to-back events masked
    csr_wr(ADDR_MASK, 32'h0);
    csr_wr(ADDR_COUNT, 32'h0);
    trig_chipselect = 1'b0; trig_write = 1'b1; trig_writedata = 32'h1; tick();
    trig_chipselect = 1'b1; trig_write = 1'b1; trig_writedata = 32'h2; tick();
    trig_chipselect = 1'b1; trig_write = 1'b0; trig_writedata = 32'h1; tick();
    trig_chipselect = 1'b0; trig_write = 1'b0; trig_writedata = 32'h0;
    csr_rd(ADDR_STATUS, 32'h0, "noevt_status");
    csr_rd(ADDR_COUNT,  32'h0, "noevt_count");
    trig(3);
    csr_rd(ADDR_STATUS, 32'h3, "burst_status");
    csr_rd(ADDR_COUNT,  32'h3, "burst_count");
    check("burst_irq_masked", {31'h0, irq}, 32'h0);
    csr_wr(ADDR_MASK, 32'h1);
    tick();
    @(negedge clk);
    check("unmask_irq", {31'h0, irq}, 32'h1);
    tick();

    // Event in the same cycle as CLEAR=3
    csr_address = ADDR_CLEAR; csr_writedata = 32'h3; csr_write = 1'b1;
    trig(1);
    csr_write = 1'b0;
    csr_rd(ADDR_STATUS, 32'h1, "race_clr_status");
    csr_rd(ADDR_COUNT,  32'h4, "race_clr_count");

    // Saturation and event racing a COUNT write
    csr_wr(ADDR_COUNT, 32'h0);
    trig(20);
    csr_rd(ADDR_COUNT, 32'hF, "sat_count");
    csr_address = ADDR_COUNT; csr_writedata = 32'h0; csr_write = 1'b1;
    trig(1);
    csr_write = 1'b0;
    csr_rd(ADDR_COUNT, 32'h1, "race_cnt_count");

    // Read wins over a simultaneous write
    csr_writedata = 32'h0;
    csr_write = 1'b1;
    csr_rd(ADDR_MASK, 32'h1, "rdwr_read");
    csr_write = 1'b0;
    csr_rd(ADDR_MASK, 32'h1, "rdwr_mask_kept");

    // Reset asserted while the FSM is in RDATA with pending=1
    csr_address = ADDR_STATUS;
    csr_read = 1'b1;
    tick();
    @(negedge clk);
    check("pre_rst_rdata", {31'h0, csr_waitrequest}, 32'h0);
    check("pre_rst_data", csr_readdata, 32'h3);
    rst_n = 1'b0;
    #2;
    check("midrst_data", csr_readdata, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_wait_idle", {31'h0, csr_waitrequest}, 32'h1);
    csr_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    csr_rd(ADDR_STATUS, 32'h0, "postrst_status");
    csr_rd(ADDR_MASK,   32'h0, "postrst_mask");
    csr_rd(ADDR_COUNT,  32'h0, "postrst_count");
    check("postrst_irq", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
